// File: rtl/frame_composer.sv
// frame_composer: renders bird, up to two pipes or a game-over checkerboard
// into a gs*gs pixel matrix one row per cycle. It then enables the display
// scanner and waits for its done pulse before returning to idle.
//
// Handshake with the display stage: e_disp_o goes high once the matrix is
// complete and stays high until the first d_disp_i=1 seen in SHOW. It then
// drops for at least one cycle, which re-arms the scanner for the next frame.
// matrix_o is only written while e_disp_o is low.
module frame_composer #(
   parameter int gs       = 8,
   parameter int BIRD_COL = 1,
   parameter int GAP      = 3,
   parameter int AW       = 3
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [AW-1:0]     bird_y_i,
   input  logic              pipe0_v_i,
   input  logic [AW-1:0]     pipe0_x_i,
   input  logic [AW-1:0]     pipe0_gap_i,
   input  logic              pipe1_v_i,
   input  logic [AW-1:0]     pipe1_x_i,
   input  logic [AW-1:0]     pipe1_gap_i,
   input  logic              game_over_i,
   input  logic              d_disp_i,
   output logic [gs*gs-1:0]  matrix_o,
   output logic              e_disp_o,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic              hit_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUILD = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Scene snapshot, frozen for the whole frame
   logic [AW-1:0] bird_y_q;
   logic          p0_v_q, p1_v_q;
   logic [AW-1:0] p0_x_q, p0_gap_q, p1_x_q, p1_gap_q;
   logic          go_q;

   logic [AW-1:0] row_cnt_q;
   logic          hit_flag_q;
   logic          last_row;

   // Per-row rendering results
   logic [gs-1:0] bird_bits, pipe_bits, go_bits, row_bits;
   logic          row_hit;
   logic [AW+1:0] row_ext, g0_lo, g0_hi, g1_lo, g1_hi;
   logic          in_gap0, in_gap1;

   assign last_row = (row_cnt_q == AW'(gs - 1));

   // Render the row currently addressed by row_cnt_q from the snapshot
   always_comb begin
      bird_bits = '0;
      pipe_bits = '0;
      go_bits   = '0;
      row_ext   = {2'b00, row_cnt_q};
      // gap end is widened by two bits so gap+GAP never wraps back into range
      g0_lo     = {2'b00, p0_gap_q};
      g0_hi     = g0_lo + (AW+2)'(GAP);
      g1_lo     = {2'b00, p1_gap_q};
      g1_hi     = g1_lo + (AW+2)'(GAP);
      in_gap0   = (row_ext >= g0_lo) && (row_ext < g0_hi);
      in_gap1   = (row_ext >= g1_lo) && (row_ext < g1_hi);
      for (int c = 0; c < gs; c++) begin
         if (p0_v_q && (p0_x_q == AW'(c)) && !in_gap0) pipe_bits[c] = 1'b1;
         if (p1_v_q && (p1_x_q == AW'(c)) && !in_gap1) pipe_bits[c] = 1'b1;
         go_bits[c] = (row_cnt_q[0] == 1'(c % 2));
      end
      if (row_cnt_q == bird_y_q) bird_bits[BIRD_COL] = 1'b1;
      row_bits = go_q ? go_bits : (bird_bits | pipe_bits);
      row_hit  = !go_q && (|(bird_bits & pipe_bits));
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i)  state_d = BUILD;
         BUILD:   if (last_row) state_d = SHOW;
         SHOW:    if (d_disp_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register and registered busy decode
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         busy_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_o  <= (state_d != IDLE);
      end
   end

   // Capture the scene on the frame request
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bird_y_q <= '0;
         p0_v_q   <= 1'b0;
         p0_x_q   <= '0;
         p0_gap_q <= '0;
         p1_v_q   <= 1'b0;
         p1_x_q   <= '0;
         p1_gap_q <= '0;
         go_q     <= 1'b0;
      end else if (state_q == IDLE && start_i) begin
         bird_y_q <= bird_y_i;
         p0_v_q   <= pipe0_v_i;
         p0_x_q   <= pipe0_x_i;
         p0_gap_q <= pipe0_gap_i;
         p1_v_q   <= pipe1_v_i;
         p1_x_q   <= pipe1_x_i;
         p1_gap_q <= pipe1_gap_i;
         go_q     <= game_over_i;
      end
   end

   // Row building, collision tracking and display handshake
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         row_cnt_q    <= '0;
         matrix_o     <= '0;
         hit_flag_q   <= 1'b0;
         hit_o        <= 1'b0;
         e_disp_o     <= 1'b0;
         frame_done_o <= 1'b0;
      end else begin
         frame_done_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  row_cnt_q  <= '0;
                  hit_flag_q <= 1'b0;
               end
            end
            BUILD: begin
               matrix_o[gs*row_cnt_q +: gs] <= row_bits;
               hit_flag_q <= hit_flag_q | row_hit;
               if (last_row) begin
                  row_cnt_q <= '0;
                  hit_o     <= hit_flag_q | row_hit;
                  e_disp_o  <= 1'b1;
               end else begin
                  row_cnt_q <= row_cnt_q + 1'b1;
               end
            end
            SHOW: begin
               if (d_disp_i) begin
                  e_disp_o     <= 1'b0;
                  frame_done_o <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_composer.sv
// tb_frame_composer: directed frames with hand-computed matrices for
// frame_composer (gs=8, BIRD_COL=1, GAP=3).
module tb_frame_composer;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        start_i = 1'b0;
   logic [2:0]  bird_y_i = '0;
   logic        pipe0_v_i = 1'b0;
   logic [2:0]  pipe0_x_i = '0;
   logic [2:0]  pipe0_gap_i = '0;
   logic        pipe1_v_i = 1'b0;
   logic [2:0]  pipe1_x_i = '0;
   logic [2:0]  pipe1_gap_i = '0;
   logic        game_over_i = 1'b0;
   logic        d_disp_i = 1'b0;
   logic [63:0] matrix_o;
   logic        e_disp_o;
   logic        busy_o;
   logic        frame_done_o;
   logic        hit_o;

   int n_cmp = 0;
   int n_err = 0;

   frame_composer dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .start_i      (start_i),
      .bird_y_i     (bird_y_i),
      .pipe0_v_i    (pipe0_v_i),
      .pipe0_x_i    (pipe0_x_i),
      .pipe0_gap_i  (pipe0_gap_i),
      .pipe1_v_i    (pipe1_v_i),
      .pipe1_x_i    (pipe1_x_i),
      .pipe1_gap_i  (pipe1_gap_i),
      .game_over_i  (game_over_i),
      .d_disp_i     (d_disp_i),
      .matrix_o     (matrix_o),
      .e_disp_o     (e_disp_o),
      .busy_o       (busy_o),
      .frame_done_o (frame_done_o),
      .hit_o        (hit_o)
   );

   // Clock
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_matrix"}, matrix_o, 64'h0);
      chk({tag, "_edisp"}, 64'(e_disp_o), 64'h0);
      chk({tag, "_busy"}, 64'(busy_o), 64'h0);
      chk({tag, "_fdone"}, 64'(frame_done_o), 64'h0);
      chk({tag, "_hit"}, 64'(hit_o), 64'h0);
   endtask

   // Request one frame, scramble inputs after the snapshot, check the built
   // frame, then poke start during SHOW and finish with a d_disp pulse.
   task automatic run_frame(input string tag, input logic [2:0] by,
                            input logic p0v, input logic [2:0] p0x, input logic [2:0] p0g,
                            input logic p1v, input logic [2:0] p1x, input logic [2:0] p1g,
                            input logic go, input logic [63:0] exp_m, input logic exp_hit);
      int cyc;
      @(negedge clk_i);
      bird_y_i = by;  game_over_i = go;
      pipe0_v_i = p0v; pipe0_x_i = p0x; pipe0_gap_i = p0g;
      pipe1_v_i = p1v; pipe1_x_i = p1x; pipe1_gap_i = p1g;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      bird_y_i = 3'($urandom_range(0, 7)); game_over_i = 1'($urandom_range(0, 1));
      pipe0_v_i = 1'b1; pipe0_x_i = 3'($urandom_range(0, 7)); pipe0_gap_i = 3'($urandom_range(0, 7));
      pipe1_v_i = 1'b1; pipe1_x_i = 3'($urandom_range(0, 7)); pipe1_gap_i = 3'($urandom_range(0, 7));
      d_disp_i = 1'b1;  // must be ignored while building
      chk({tag, "_busy_build"}, 64'(busy_o), 64'h1);
      cyc = 1;
      while (!e_disp_o && cyc < 20) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      d_disp_i = 1'b0;
      chk({tag, "_edisp_latency"}, 64'(cyc), 64'd9);
      chk({tag, "_matrix"}, matrix_o, exp_m);
      chk({tag, "_hit"}, 64'(hit_o), 64'(exp_hit));
      chk({tag, "_busy_show"}, 64'(busy_o), 64'h1);
      // start during SHOW must not rebuild or disturb the frame
      start_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk({tag, "_show_hold_edisp"}, 64'(e_disp_o), 64'h1);
      chk({tag, "_show_hold_matrix"}, matrix_o, exp_m);
      start_i = 1'b0;
      d_disp_i = 1'b1;
      @(posedge clk_i); #1;
      d_disp_i = 1'b0;
      chk({tag, "_done_edisp"}, 64'(e_disp_o), 64'h0);
      chk({tag, "_done_pulse"}, 64'(frame_done_o), 64'h1);
      chk({tag, "_done_busy"}, 64'(busy_o), 64'h0);
      @(posedge clk_i); #1;
      chk({tag, "_done_pulse_end"}, 64'(frame_done_o), 64'h0);
      chk({tag, "_idle_busy"}, 64'(busy_o), 64'h0);
      chk({tag, "_idle_matrix"}, matrix_o, exp_m);
   endtask

   initial begin
      // Reset
      repeat (3) @(posedge clk_i);
      #1;
      chk_all_zero("reset");
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // Bird alone at (3,1)
      run_frame("bird_only", 3'd3, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0,
                64'h0000_0000_0200_0000, 1'b0);
      // Pipe0 col 5, rows 2..4 open; bird at (6,1)
      run_frame("pipe0_gap2", 3'd6, 1'b1, 3'd5, 3'd2, 1'b0, 3'd0, 3'd0, 1'b0,
                64'h2022_2000_0000_2020, 1'b0);
      // Pipe0 col 1, gap 6 (rows 6,7 open, no wrap); bird at (2,1) collides
      run_frame("pipe0_hit", 3'd2, 1'b1, 3'd1, 3'd6, 1'b0, 3'd0, 3'd0, 1'b0,
                64'h0000_0202_0202_0202, 1'b1);
      // Game over with a colliding scene: checkerboard, hit forced low
      run_frame("game_over", 3'd2, 1'b1, 3'd1, 3'd6, 1'b0, 3'd0, 3'd0, 1'b1,
                64'hAA55_AA55_AA55_AA55, 1'b0);
      // Both pipes on col 7, gaps complementary: ORed to full column; bird (0,1)
      run_frame("coincident", 3'd0, 1'b1, 3'd7, 3'd0, 1'b1, 3'd7, 3'd5, 1'b0,
                64'h8080_8080_8080_8082, 1'b0);
      // Pipe1 col 1 gap 0, bird inside gap; invalid pipe0 on col 1 ignored
      run_frame("pipe1_gap", 3'd1, 1'b0, 3'd1, 3'd6, 1'b1, 3'd1, 3'd0, 1'b0,
                64'h0202_0202_0200_0200, 1'b0);
      // Pipe1 col 1 gap 5 (rows 5..7 open), bird at (4,1) collides with pipe1
      run_frame("pipe1_hit", 3'd4, 1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 3'd5, 1'b0,
                64'h0000_0002_0202_0202, 1'b1);

      // Asynchronous reset in the middle of BUILD
      @(negedge clk_i);
      bird_y_i = 3'd5; pipe0_v_i = 1'b1; pipe0_x_i = 3'd3; pipe0_gap_i = 3'd0;
      pipe1_v_i = 1'b0; game_over_i = 1'b0;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #2;
      rst_n_i = 1'b0;
      #1;
      chk_all_zero("midreset");
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      chk("midreset_idle_busy", 64'(busy_o), 64'h0);
      chk("midreset_idle_edisp", 64'(e_disp_o), 64'h0);
      run_frame("after_reset", 3'd3, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0,
                64'h0000_0000_0200_0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
